// File: rtl/rf_wb_pkg.sv
// Shared types for the register-file writeback queue: selector encodings,
// the link-register address and the default-width queue entry.
package rf_wb_pkg;

  localparam int unsigned RF_AW = 5;
  localparam int unsigned RF_DW = 32;

  localparam logic [RF_AW-1:0] RA_ADDR = 5'd31;

  typedef enum logic [1:0] {
    DST_RT     = 2'd0,
    DST_RD     = 2'd1,
    DST_RA     = 2'd2,
    DST_RT_ALT = 2'd3
  } dst_sel_e;

  typedef enum logic [1:0] {
    SRC_MEM  = 2'd0,
    SRC_LINK = 2'd1,
    SRC_ALU  = 2'd2,
    SRC_NONE = 2'd3
  } src_sel_e;

  typedef struct packed {
    logic [RF_AW-1:0] dst;
    logic [RF_DW-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/rf_wb_entry_fmt.sv
// Combinational formatting of a completed result into a queue entry:
// destination register (rt/rd/r31) and write data (mem/link/alu).
module rf_wb_entry_fmt
  import rf_wb_pkg::*;
#(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 32
) (
  input  logic [1:0]    dstSel,
  input  logic [AW-1:0] rt,
  input  logic [AW-1:0] rd,
  input  logic [1:0]    srcSel,
  input  logic [DW-1:0] memData,
  input  logic [DW-1:0] linkData,
  input  logic [DW-1:0] aluData,
  output logic [AW-1:0] dst,
  output logic [DW-1:0] data
);

  always_comb begin
    dst = rt;
    case (dst_sel_e'(dstSel))
      DST_RD:  dst = rd;
      DST_RA:  dst = AW'(RA_ADDR);
      default: dst = rt;
    endcase
  end

  // The unused source code yields zero rather than a stale operand.
  always_comb begin
    data = '0;
    case (src_sel_e'(srcSel))
      SRC_MEM:  data = memData;
      SRC_LINK: data = linkData;
      SRC_ALU:  data = aluData;
      default:  data = '0;
    endcase
  end

endmodule

// File: rtl/rf_writeback_queue.sv
// Register-file writeback queue: buffers completed results, drains one write
// per cycle in FIFO order and flags RAW hazards on rs/rt.
// Optional forwarding outputs are enabled by defining RF_WBQ_FORWARD_EN.
module rf_writeback_queue
  import rf_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32,
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_dst_sel,
  input  logic [AW-1:0] in_rt,
  input  logic [AW-1:0] in_rd,
  input  logic [1:0]    in_src_sel,
  input  logic [DW-1:0] in_mem_data,
  input  logic [DW-1:0] in_link_data,
  input  logic [DW-1:0] in_alu_data,
  input  logic          wb_stall,
  input  logic [AW-1:0] rs_addr,
  input  logic [AW-1:0] rt_addr,
  output logic          rs_pending,
  output logic          rt_pending,
  output logic          RegWrite,
  output logic [AW-1:0] WriteRegister,
  output logic [DW-1:0] WriteData,
  output logic [CW-1:0] count
`ifdef RF_WBQ_FORWARD_EN
  ,
  output logic [DW-1:0] rs_fwd_data,
  output logic [DW-1:0] rt_fwd_data
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [AW-1:0] dstMem  [DEPTH];
  logic [DW-1:0] dataMem [DEPTH];
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic [CW-1:0] occ;

  logic [AW-1:0] fmtDst;
  logic [DW-1:0] fmtData;
  logic          full;
  logic          empty;
  logic          doPush;
  logic          doStore;
  logic          doPop;

  rf_wb_entry_fmt #(
    .AW (AW),
    .DW (DW)
  ) u_fmt (
    .dstSel   (in_dst_sel),
    .rt       (in_rt),
    .rd       (in_rd),
    .srcSel   (in_src_sel),
    .memData  (in_mem_data),
    .linkData (in_link_data),
    .aluData  (in_alu_data),
    .dst      (fmtDst),
    .data     (fmtData)
  );

  assign full     = (occ == CW'(DEPTH));
  assign empty    = (occ == '0);
  assign in_ready = !full;
  assign count    = occ;

  // A write to r0 completes the handshake but never occupies a slot.
  assign doPush  = in_valid && in_ready;
  assign doStore = doPush && (fmtDst != '0);

  assign RegWrite      = !empty && !wb_stall;
  assign doPop         = RegWrite;
  assign WriteRegister = empty ? '0 : dstMem[rdPtr];
  assign WriteData     = empty ? '0 : dataMem[rdPtr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      occ   <= '0;
    end else begin
      if (doStore) begin
        wrPtr <= wrPtr + PW'(1);
      end
      if (doPop) begin
        rdPtr <= rdPtr + PW'(1);
      end
      occ <= occ + CW'(doStore) - CW'(doPop);
    end
  end

  always_ff @(posedge clk) begin
    if (doStore) begin
      dstMem[wrPtr]  <= fmtDst;
      dataMem[wrPtr] <= fmtData;
    end
  end

  // Walk occupied slots oldest-to-youngest so the last match is the youngest.
  logic          rsHit;
  logic          rtHit;
`ifdef RF_WBQ_FORWARD_EN
  logic [DW-1:0] rsHitData;
  logic [DW-1:0] rtHitData;
`endif

  always_comb begin
    logic [PW-1:0] idx;
    idx   = '0;
    rsHit = 1'b0;
    rtHit = 1'b0;
`ifdef RF_WBQ_FORWARD_EN
    rsHitData = '0;
    rtHitData = '0;
`endif
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = rdPtr + PW'(k);
      if (CW'(k) < occ) begin
        if (dstMem[idx] == rs_addr) begin
          rsHit = 1'b1;
`ifdef RF_WBQ_FORWARD_EN
          rsHitData = dataMem[idx];
`endif
        end
        if (dstMem[idx] == rt_addr) begin
          rtHit = 1'b1;
`ifdef RF_WBQ_FORWARD_EN
          rtHitData = dataMem[idx];
`endif
        end
      end
    end
  end

  assign rs_pending = rsHit && (rs_addr != '0);
  assign rt_pending = rtHit && (rt_addr != '0);

`ifdef RF_WBQ_FORWARD_EN
  assign rs_fwd_data = rs_pending ? rsHitData : '0;
  assign rt_fwd_data = rt_pending ? rtHitData : '0;
`endif

  assert property (@(posedge clk) disable iff (rst) occ <= CW'(DEPTH));
  assert property (@(posedge clk) disable iff (rst) RegWrite |-> (WriteRegister != '0));

endmodule
